// File: rtl/if_id_register.sv
// IF/ID pipeline register: captures fetch output on hit, bubbles on miss/flush, holds on stall.
// Also keeps saturating miss/stall/flush counters and the longest I-cache miss streak.
module if_id_register #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clkk,
  input  logic             rstt,
  input  logic [31:0]      adderOutput,
  input  logic [31:0]      ins,
  input  logic             hitt,
  input  logic             stall,
  input  logic             flush,
  output logic [31:0]      idIns,
  output logic [31:0]      idPcPlus4,
  output logic             idValid,
  output logic [CNT_W-1:0] missCnt,
  output logic [CNT_W-1:0] stallCnt,
  output logic [CNT_W-1:0] flushCnt,
  output logic [CNT_W-1:0] maxMiss
);

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] MISS = 1'b1;

  logic [0:0]       state, state_nxt;
  logic [CNT_W-1:0] miss_len, miss_len_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state_nxt    = state;
    miss_len_nxt = miss_len;
    case (state)
      RUN: begin
        if (!hitt) begin
          state_nxt    = MISS;
          miss_len_nxt = CNT_W'(1);
        end
      end
      default: begin
        if (hitt) begin
          state_nxt    = RUN;
          miss_len_nxt = '0;
        end else begin
          miss_len_nxt = sat_inc(miss_len);
        end
      end
    endcase
  end

  // Fetch data is only sampled when hitt=1, so garbage on a miss never propagates.
  always_ff @(posedge clkk) begin
    if (rstt) begin
      idIns     <= NOP_WORD;
      idPcPlus4 <= '0;
      idValid   <= 1'b0;
    end else if (flush) begin
      idIns     <= NOP_WORD;
      idPcPlus4 <= '0;
      idValid   <= 1'b0;
    end else if (!stall) begin
      if (hitt) begin
        idIns     <= ins;
        idPcPlus4 <= adderOutput;
        idValid   <= 1'b1;
      end else begin
        idIns     <= NOP_WORD;
        idValid   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clkk) begin
    if (rstt) begin
      state    <= RUN;
      miss_len <= '0;
      maxMiss  <= '0;
      missCnt  <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      state    <= state_nxt;
      miss_len <= miss_len_nxt;
      if (miss_len_nxt > maxMiss) maxMiss <= miss_len_nxt;
      if (!hitt)           missCnt  <= sat_inc(missCnt);
      if (stall && !flush) stallCnt <= sat_inc(stallCnt);
      if (flush)           flushCnt <= sat_inc(flushCnt);
    end
  end

endmodule

// File: tb/tb_if_id_register.sv
// Bench for if_id_register: directed vector table, hand sequences, and randomized traffic
// checked against a cycle-level behavioural model (16-bit and 4-bit counter instances).
module tb_if_id_register;

  logic        clkk = 1'b0;
  logic        rstt, hitt, stall, flush;
  logic [31:0] adderOutput, ins;

  logic [31:0] a_ins, a_pc, b_ins, b_pc;
  logic        a_vld, b_vld;
  logic [15:0] a_miss, a_stall, a_flush, a_max;
  logic [3:0]  b_miss, b_stall, b_flush, b_max;

  int n_checks = 0;
  int n_fail   = 0;

  if_id_register #(.NOP_WORD(32'h0), .CNT_W(16)) dut16 (
    .clkk(clkk), .rstt(rstt), .adderOutput(adderOutput), .ins(ins), .hitt(hitt),
    .stall(stall), .flush(flush), .idIns(a_ins), .idPcPlus4(a_pc), .idValid(a_vld),
    .missCnt(a_miss), .stallCnt(a_stall), .flushCnt(a_flush), .maxMiss(a_max));

  if_id_register #(.NOP_WORD(32'h0), .CNT_W(4)) dut4 (
    .clkk(clkk), .rstt(rstt), .adderOutput(adderOutput), .ins(ins), .hitt(hitt),
    .stall(stall), .flush(flush), .idIns(b_ins), .idPcPlus4(b_pc), .idValid(b_vld),
    .missCnt(b_miss), .stallCnt(b_stall), .flushCnt(b_flush), .maxMiss(b_max));

  always #5 clkk = ~clkk;

  // Behavioural model: unbounded integer counts, saturation applied only when compared.
  logic [31:0] m_ins, m_pc;
  logic        m_vld;
  int m_miss, m_stall, m_flush, m_streak, m_max;

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic h, input logic s, input logic f,
                            input logic [31:0] i, input logic [31:0] p);
    if (r) begin
      m_ins = 32'h0; m_pc = 32'h0; m_vld = 1'b0;
      m_miss = 0; m_stall = 0; m_flush = 0; m_streak = 0; m_max = 0;
    end else begin
      if (f) begin
        m_ins = 32'h0; m_pc = 32'h0; m_vld = 1'b0;
      end else if (!s) begin
        if (h) begin m_ins = i; m_pc = p; m_vld = 1'b1; end
        else   begin m_ins = 32'h0; m_vld = 1'b0; end
      end
      if (!h) m_miss++;
      if (s && !f) m_stall++;
      if (f) m_flush++;
      m_streak = h ? 0 : m_streak + 1;
      if (m_streak > m_max) m_max = m_streak;
    end
  endtask

  // Drive one cycle, advance the model, check both instances against it 1ns after the edge.
  task automatic step(input logic r, input logic h, input logic s, input logic f,
                      input logic [31:0] i, input logic [31:0] p);
    rstt = r; hitt = h; stall = s; flush = f; ins = i; adderOutput = p;
    @(posedge clkk);
    model_edge(r, h, s, f, i, p);
    #1;
    chk("idIns",      a_ins,  m_ins);
    chk("idPcPlus4",  a_pc,   m_pc);
    chk("idValid",    32'(a_vld), 32'(m_vld));
    chk("missCnt",    32'(a_miss),  32'(sat(m_miss, 16)));
    chk("stallCnt",   32'(a_stall), 32'(sat(m_stall, 16)));
    chk("flushCnt",   32'(a_flush), 32'(sat(m_flush, 16)));
    chk("maxMiss",    32'(a_max),   32'(sat(m_max, 16)));
    chk("idIns_w4",   b_ins,  m_ins);
    chk("missCnt_w4", 32'(b_miss),  32'(sat(m_miss, 4)));
    chk("stallCnt_w4",32'(b_stall), 32'(sat(m_stall, 4)));
    chk("flushCnt_w4",32'(b_flush), 32'(sat(m_flush, 4)));
    chk("maxMiss_w4", 32'(b_max),   32'(sat(m_max, 4)));
  endtask

  typedef struct packed {
    logic        r, h, s, f;
    logic [31:0] i, p;
    logic [31:0] e_ins, e_pc;
    logic        e_vld;
  } vec_t;

  vec_t tbl[9];

  initial begin
    rstt = 1'b1; hitt = 1'b0; stall = 1'b0; flush = 1'b0; ins = '0; adderOutput = '0;
    m_ins = '0; m_pc = '0; m_vld = 1'b0;
    m_miss = 0; m_stall = 0; m_flush = 0; m_streak = 0; m_max = 0;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 32'h40, 32'h0,         32'h0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h44, 32'h0,         32'h0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h8C01_0004, 32'h4,  32'h8C01_0004, 32'h4, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0022_1820, 32'h8,  32'h0022_1820, 32'h8, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hC,  32'h0022_1820, 32'h8, 1'b1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hCAFE_F00D, 32'h10, 32'h0022_1820, 32'h8, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 32'hBAD0_BAD0, 32'h14, 32'h0022_1820, 32'h8, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1111_1111, 32'h18, 32'h0,         32'h0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h2222_2222, 32'h1C, 32'h2222_2222, 32'h1C, 1'b1};

    @(negedge clkk);
    for (int k = 0; k < 9; k++) begin
      step(tbl[k].r, tbl[k].h, tbl[k].s, tbl[k].f, tbl[k].i, tbl[k].p);
      chk($sformatf("tbl%0d_idIns", k),     a_ins, tbl[k].e_ins);
      chk($sformatf("tbl%0d_idPcPlus4", k), a_pc,  tbl[k].e_pc);
      chk($sformatf("tbl%0d_idValid", k),   32'(a_vld), 32'(tbl[k].e_vld));
    end
    // Three stall cycles (one during a miss), flush-over-stall not counted as a stall.
    chk("stall_total", 32'(a_stall), 32'd3);
    chk("flush_total", 32'(a_flush), 32'd1);
    chk("miss_total",  32'(a_miss),  32'd1);

    // Miss streak: 4 misses, hit, 2 misses -> maxMiss stays at 4, PC+4 held during misses.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
      chk("streak_valid", 32'(a_vld), 32'd0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'hAAAA_0001, 32'h24);
    chk("streak_hit_pc", a_pc, 32'h24);
    for (int k = 0; k < 2; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
      chk("streak_valid2", 32'(a_vld), 32'd0);
      chk("streak_pc_hold", a_pc, 32'h24);
    end
    chk("streak_missCnt", 32'(a_miss), 32'd6);
    chk("streak_maxMiss", 32'(a_max),  32'd4);

    // Saturation on the 4-bit instance, then reset in the middle of the miss.
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < 20; k++) step(1'b0, 1'b0, 1'b0, 1'b0, $urandom, $urandom);
    chk("sat_missCnt_w4", 32'(b_miss), 32'd15);
    chk("sat_maxMiss_w4", 32'(b_max),  32'd15);
    chk("sat_maxMiss_w16", 32'(a_max), 32'd20);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("midrst_missCnt_w4", 32'(b_miss), 32'd0);
    chk("midrst_maxMiss_w4", 32'(b_max),  32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    chk("midrst_run_maxMiss", 32'(b_max), 32'd1);

    // Randomized traffic against the model.
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
           $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
